mux_estrutural: RTL and testbench

- Parameterised N-to-1 multiplexer built structurally: a select decoder feeds an AND-OR gate network, with a registered output stage.
- Default configuration is a 4:1, 1-bit mux (d[3:0], s[1:0]).
- Used as a leaf datapath-selection cell.
- Exposes both the combinational result and a registered copy.

---
 rtl/mux_estrutural_pkg.sv | 16 +
 rtl/mux_estrutural_dec.sv | 25 ++
 rtl/mux_estrutural.sv | 65 ++++++
 tb/tb_mux_estrutural.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mux_estrutural_pkg.sv
// rtl/mux_estrutural_pkg.sv - shared defaults and select-width helper for the structural mux
package mux_estrutural_pkg;

  localparam int MUX_N_INPUTS = 4;
  localparam int MUX_SEL_W    = 2;
  localparam int MUX_DATA_W   = 1;

  // Smallest select width able to address n inputs.
  function automatic int min_sel_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/mux_estrutural_dec.sv
// rtl/mux_estrutural_dec.sv - gate-level select decoder producing one-hot lines h[i] = (s == i)
module mux_estrutural_dec
  import mux_estrutural_pkg::*;
#(
  parameter int N_INPUTS = MUX_N_INPUTS,
  parameter int SEL_W    = MUX_SEL_W
) (
  input  logic [SEL_W-1:0]    s,
  output logic [N_INPUTS-1:0] h
);

  // Each line ANDs true or inverted select bits matching its index; codes >= N_INPUTS get no line.
  for (genvar i = 0; i < N_INPUTS; i++) begin : g_line
    logic [SEL_W-1:0] lit;
    for (genvar b = 0; b < SEL_W; b++) begin : g_bit
      if (((i >> b) & 1) == 1) begin : g_pos
        assign lit[b] = s[b];
      end else begin : g_neg
        assign lit[b] = ~s[b];
      end
    end
    assign h[i] = &lit;
  end

endmodule

// File: rtl/mux_estrutural.sv
// rtl/mux_estrutural.sv - structural N:1 mux (decoder + AND-OR plane) with registered output
// Optional out-of-range select flag sel_err under MUX_ESTRUTURAL_SEL_CHECK_EN.
module mux_estrutural
  import mux_estrutural_pkg::*;
#(
  parameter int N_INPUTS = MUX_N_INPUTS,
  parameter int SEL_W    = MUX_SEL_W,
  parameter int DATA_W   = MUX_DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_INPUTS*DATA_W-1:0] d,
  input  logic [SEL_W-1:0]           s,
  input  logic                       en,
  output logic [DATA_W-1:0]          y_comb,
  output logic [DATA_W-1:0]          y
`ifdef MUX_ESTRUTURAL_SEL_CHECK_EN
  ,
  output logic                       sel_err
`endif
);

  if (SEL_W < min_sel_w(N_INPUTS)) begin : g_bad_sel_w
    $error("mux_estrutural: SEL_W too narrow for N_INPUTS");
  end

  logic [N_INPUTS-1:0] h;

  mux_estrutural_dec #(
    .N_INPUTS (N_INPUTS),
    .SEL_W    (SEL_W)
  ) u_dec (
    .s (s),
    .h (h)
  );

  // Per data bit: AND each input bit with its decoder line, then OR the terms.
  for (genvar k = 0; k < DATA_W; k++) begin : g_bit
    logic [N_INPUTS-1:0] term;
    for (genvar i = 0; i < N_INPUTS; i++) begin : g_term
      assign term[i] = h[i] & d[i*DATA_W + k];
    end
    assign y_comb[k] = |term;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y <= '0;
    end else if (en) begin
      y <= y_comb;
    end
  end

`ifdef MUX_ESTRUTURAL_SEL_CHECK_EN
  // No active decoder line is exactly the out-of-range condition.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (en) begin
      sel_err <= ~(|h);
    end
  end
`endif

endmodule

// File: tb/tb_mux_estrutural.sv
// tb/tb_mux_estrutural.sv - directed self-checking bench for mux_estrutural (default and 3x8 configs)
module tb_mux_estrutural;

  logic        clk;
  logic        rst;

  logic [3:0]  d_a;
  logic [1:0]  s_a;
  logic        en_a;
  logic        yc_a;
  logic        y_a;

  logic [23:0] d_b;
  logic [1:0]  s_b;
  logic        en_b;
  logic [7:0]  yc_b;
  logic [7:0]  y_b;

`ifdef MUX_ESTRUTURAL_SEL_CHECK_EN
  logic        err_a;
  logic        err_b;
`endif

  int checks;
  int errors;

  mux_estrutural u_dut_a (
    .clk    (clk),
    .rst    (rst),
    .d      (d_a),
    .s      (s_a),
    .en     (en_a),
    .y_comb (yc_a),
    .y      (y_a)
`ifdef MUX_ESTRUTURAL_SEL_CHECK_EN
    ,
    .sel_err (err_a)
`endif
  );

  mux_estrutural #(
    .N_INPUTS (3),
    .SEL_W    (2),
    .DATA_W   (8)
  ) u_dut_b (
    .clk    (clk),
    .rst    (rst),
    .d      (d_b),
    .s      (s_b),
    .en     (en_b),
    .y_comb (yc_b),
    .y      (y_b)
`ifdef MUX_ESTRUTURAL_SEL_CHECK_EN
    ,
    .sel_err (err_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] exp_step;
    logic       exp_bit;

    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    en_a     = 1'b1;
    en_b     = 1'b1;
    d_a      = 4'b0000;
    s_a      = 2'd0;
    d_b      = {8'hC3, 8'h5A, 8'hFF};
    s_b      = 2'd0;
    exp_step = 4'b1010;

    tick();
    check("reset_y_a", {7'd0, y_a}, 8'h00);
    check("reset_y_b", y_b, 8'h00);
    check("reset_ycomb_b", yc_b, 8'hFF);
    rst = 1'b0;

    // d=1010 stepped through every select
    d_a = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      s_a = 2'(i);
      #1;
      check("step_ycomb", {7'd0, yc_a}, {7'd0, exp_step[i]});
      tick();
      check("step_y", {7'd0, y_a}, {7'd0, exp_step[i]});
      tick();
    end

    // reset while loaded, y_comb stays live
    d_a = 4'b1111;
    s_a = 2'd3;
    rst = 1'b1;
    #1;
    check("rst_ycomb_pre", {7'd0, yc_a}, 8'h01);
    tick();
    check("rst_y", {7'd0, y_a}, 8'h00);
    check("rst_ycomb", {7'd0, yc_a}, 8'h01);
    rst = 1'b0;
    tick();
    check("rel_y", {7'd0, y_a}, 8'h01);

    // hold with en=0
    en_a = 1'b0;
    d_a  = 4'b1010;
    s_a  = 2'd0;
    #1;
    check("hold_ycomb", {7'd0, yc_a}, 8'h00);
    tick();
    check("hold_y", {7'd0, y_a}, 8'h01);
    tick();
    check("hold_y2", {7'd0, y_a}, 8'h01);
    en_a = 1'b1;
    tick();
    check("load_y", {7'd0, y_a}, 8'h00);

    // reset overrides en=0
    s_a = 2'd1;
    tick();
    check("pre_rst_y", {7'd0, y_a}, 8'h01);
    en_a = 1'b0;
    rst  = 1'b1;
    tick();
    check("rst_over_en", {7'd0, y_a}, 8'h00);
    rst  = 1'b0;
    en_a = 1'b1;

    // 3-input 8-bit config, including out-of-range select
    s_b = 2'd3;
    #1;
    check("b_oor_ycomb", yc_b, 8'h00);
    tick();
    check("b_oor_y", y_b, 8'h00);
`ifdef MUX_ESTRUTURAL_SEL_CHECK_EN
    check("b_oor_err", {7'd0, err_b}, 8'h01);
`endif
    s_b = 2'd1;
    #1;
    check("b_s1_ycomb", yc_b, 8'h5A);
    tick();
    check("b_s1_y", y_b, 8'h5A);
`ifdef MUX_ESTRUTURAL_SEL_CHECK_EN
    check("b_s1_err", {7'd0, err_b}, 8'h00);
`endif
    s_b = 2'd0;
    #1;
    check("b_s0_ycomb", yc_b, 8'hFF);
    s_b = 2'd2;
    #1;
    check("b_s2_ycomb", yc_b, 8'hC3);
    tick();
    check("b_s2_y", y_b, 8'hC3);

    // exhaustive sweep, default config
    for (int dv = 0; dv < 16; dv++) begin
      for (int sv = 0; sv < 4; sv++) begin
        d_a = 4'(dv);
        s_a = 2'(sv);
        exp_bit = 1'((dv >> sv) & 1);
        #1;
        check("sweep_ycomb", {7'd0, yc_a}, {7'd0, exp_bit});
        tick();
        check("sweep_y", {7'd0, y_a}, {7'd0, exp_bit});
`ifdef MUX_ESTRUTURAL_SEL_CHECK_EN
        check("sweep_err", {7'd0, err_a}, 8'h00);
`endif
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
